// File: rtl/vit_pkg.sv
// Shared Viterbi decoder constants: metric widths, trellis size, normalisation
// step and the start-of-frame path-metric seed.
package vit_pkg;

  localparam int unsigned PM_W       = 8;
  localparam int unsigned BM_W       = 2;
  localparam int unsigned NUM_STATES = 64;
  localparam int unsigned NORM_VAL   = 32'(1) << (PM_W - 2);
  localparam int unsigned PM_MAX     = (32'(1) << PM_W) - 32'(1);

  // Normalisation step for an arbitrary metric width: a quarter of the range.
  function automatic int unsigned norm_val_f(input int unsigned w);
    return 32'(1) << (w - 32'(2));
  endfunction

  // State 0 starts as the known-good path; every other state starts one step behind.
  function automatic int unsigned init_pm(input int unsigned idx, input int unsigned w);
    return (idx == 32'(0)) ? 32'(0) : norm_val_f(w);
  endfunction

endpackage

// File: rtl/acs_add_cmp.sv
// Combinational add/normalise/compare/clamp datapath for one ACS node.
// sel is already clamped to the PM_W range; ovf flags that the clamp fired.
module acs_add_cmp
  import vit_pkg::*;
#(
  parameter int unsigned PM_W = vit_pkg::PM_W,
  parameter int unsigned BM_W = vit_pkg::BM_W
) (
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [BM_W-1:0] bm_a,
  input  logic [BM_W-1:0] bm_b,
  input  logic            norm,
  output logic [PM_W-1:0] sel,
  output logic            dec,
  output logic            ovf
);

  localparam int unsigned SW = PM_W + 1;
  localparam logic [SW-1:0] NV = SW'(norm_val_f(PM_W));

  logic [SW-1:0] sa_raw;
  logic [SW-1:0] sb_raw;
  logic [SW-1:0] sa;
  logic [SW-1:0] sb;
  logic [SW-1:0] sel_wide;

  // One extra bit holds the carry so overflow is visible before clamping.
  always_comb begin
    sa_raw   = SW'(pm_a) + SW'(bm_a);
    sb_raw   = SW'(pm_b) + SW'(bm_b);
    sa       = sa_raw;
    sb       = sb_raw;
    if (norm) begin
      sa = (sa_raw >= NV) ? (sa_raw - NV) : '0;
      sb = (sb_raw >= NV) ? (sb_raw - NV) : '0;
    end
    dec      = (sb < sa);
    sel_wide = dec ? sb : sa;
    ovf      = sel_wide[PM_W];
    sel      = ovf ? '1 : sel_wide[PM_W-1:0];
  end

endmodule

// File: rtl/acs_node.sv
// Add-compare-select node: registers one trellis state's path metric, its
// survivor decision bit and a sticky saturation flag.
module acs_node
  import vit_pkg::*;
#(
  parameter int unsigned PM_W      = vit_pkg::PM_W,
  parameter int unsigned BM_W      = vit_pkg::BM_W,
  parameter int unsigned STATE_IDX = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sof,
  input  logic            in_valid,
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [BM_W-1:0] bm_a,
  input  logic [BM_W-1:0] bm_b,
  input  logic            norm,
  output logic            out_valid,
  output logic [PM_W-1:0] pm_out,
  output logic            dec_bit,
  output logic            pm_msb,
  output logic            sat
);

  localparam logic [PM_W-1:0] INIT_PM = PM_W'(init_pm(STATE_IDX, PM_W));

  logic [PM_W-1:0] sel;
  logic            dec;
  logic            ovf;

  logic [PM_W-1:0] pm_q,  pm_d;
  logic            dec_q, dec_d;
  logic            vld_q, vld_d;
  logic            sat_q, sat_d;

  acs_add_cmp #(
    .PM_W (PM_W),
    .BM_W (BM_W)
  ) u_add_cmp (
    .pm_a (pm_a),
    .pm_b (pm_b),
    .bm_a (bm_a),
    .bm_b (bm_b),
    .norm (norm),
    .sel  (sel),
    .dec  (dec),
    .ovf  (ovf)
  );

  // sof wins over in_valid; the data beat presented with it is dropped.
  always_comb begin
    pm_d  = pm_q;
    dec_d = dec_q;
    sat_d = sat_q;
    vld_d = 1'b0;
    if (sof) begin
      pm_d  = INIT_PM;
      dec_d = 1'b0;
      sat_d = 1'b0;
    end else if (in_valid) begin
      pm_d  = sel;
      dec_d = dec;
      sat_d = sat_q | ovf;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pm_q  <= INIT_PM;
      dec_q <= 1'b0;
      vld_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      pm_q  <= pm_d;
      dec_q <= dec_d;
      vld_q <= vld_d;
      sat_q <= sat_d;
    end
  end

  assign pm_out    = pm_q;
  assign dec_bit   = dec_q;
  assign out_valid = vld_q;
  assign sat       = sat_q;
  // Feeds the array-wide AND that decides when to normalise.
  assign pm_msb    = pm_q[PM_W-1];

endmodule

// File: tb/tb_acs_node.sv
// Self-checking bench for acs_node: three instances (state 0, 5, 3) share
// stimulus and are compared against an integer reference model every cycle.
module tb_acs_node;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst, sof, in_valid, norm;
  logic [7:0] pm_a, pm_b;
  logic [1:0] bm_a, bm_b;

  logic [7:0] pm_out    [NI];
  logic       dec_bit   [NI];
  logic       out_valid [NI];
  logic       pm_msb    [NI];
  logic       sat       [NI];

  int checks = 0;
  int errors = 0;

  int m_pm  [NI];
  int m_dec [NI];
  int m_vld [NI];
  int m_sat [NI];
  int m_init[NI] = '{0, 64, 64};

  always #5 clk = ~clk;

  acs_node #(.PM_W(8), .BM_W(2), .STATE_IDX(0)) dut0 (
    .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid),
    .pm_a(pm_a), .pm_b(pm_b), .bm_a(bm_a), .bm_b(bm_b), .norm(norm),
    .out_valid(out_valid[0]), .pm_out(pm_out[0]), .dec_bit(dec_bit[0]),
    .pm_msb(pm_msb[0]), .sat(sat[0]));

  acs_node #(.PM_W(8), .BM_W(2), .STATE_IDX(5)) dut5 (
    .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid),
    .pm_a(pm_a), .pm_b(pm_b), .bm_a(bm_a), .bm_b(bm_b), .norm(norm),
    .out_valid(out_valid[1]), .pm_out(pm_out[1]), .dec_bit(dec_bit[1]),
    .pm_msb(pm_msb[1]), .sat(sat[1]));

  acs_node #(.PM_W(8), .BM_W(2), .STATE_IDX(3)) dut3 (
    .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid),
    .pm_a(pm_a), .pm_b(pm_b), .bm_a(bm_a), .bm_b(bm_b), .norm(norm),
    .out_valid(out_valid[2]), .pm_out(pm_out[2]), .dec_bit(dec_bit[2]),
    .pm_msb(pm_msb[2]), .sat(sat[2]));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour in plain integer arithmetic.
  task automatic model_step();
    int sa, sb, s, d;
    for (int i = 0; i < NI; i++) begin
      if (rst || sof) begin
        m_pm[i]  = m_init[i];
        m_dec[i] = 0;
        m_sat[i] = 0;
        m_vld[i] = 0;
      end else if (in_valid) begin
        sa = int'(pm_a) + int'(bm_a);
        sb = int'(pm_b) + int'(bm_b);
        if (norm) begin
          sa = (sa >= 64) ? sa - 64 : 0;
          sb = (sb >= 64) ? sb - 64 : 0;
        end
        d = (sb < sa) ? 1 : 0;
        s = d ? sb : sa;
        if (s > 255) begin
          m_pm[i]  = 255;
          m_sat[i] = 1;
        end else begin
          m_pm[i] = s;
        end
        m_dec[i] = d;
        m_vld[i] = 1;
      end else begin
        m_vld[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("pm_out[%0d]", i),    int'(pm_out[i]),    m_pm[i]);
      check($sformatf("dec_bit[%0d]", i),   int'(dec_bit[i]),   m_dec[i]);
      check($sformatf("out_valid[%0d]", i), int'(out_valid[i]), m_vld[i]);
      check($sformatf("sat[%0d]", i),       int'(sat[i]),       m_sat[i]);
      check($sformatf("pm_msb[%0d]", i),    int'(pm_msb[i]),    (m_pm[i] >= 128) ? 1 : 0);
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic v,
                       input int pa, input int ba, input int pb, input int bb,
                       input logic n);
    rst      = r;
    sof      = s;
    in_valid = v;
    pm_a     = 8'(pa);
    bm_a     = 2'(ba);
    pm_b     = 8'(pb);
    bm_b     = 2'(bb);
    norm     = n;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; sof = 1'b0; in_valid = 1'b0; norm = 1'b0;
    pm_a = '0; pm_b = '0; bm_a = '0; bm_b = '0;

    // Reset values per state index
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_pm_s0", int'(pm_out[0]), 0);
    check("rst_pm_s5", int'(pm_out[1]), 64);
    check("rst_vld_s0", int'(out_valid[0]), 0);
    check("rst_sat_s0", int'(sat[0]), 0);
    check("rst_dec_s0", int'(dec_bit[0]), 0);

    cycle(0, 0, 1, 10, 2, 9, 1, 0);
    check("basic_pm", int'(pm_out[0]), 10);
    check("basic_dec", int'(dec_bit[0]), 1);
    check("basic_vld", int'(out_valid[0]), 1);

    cycle(0, 0, 1, 5, 1, 6, 0, 0);
    check("tie_pm", int'(pm_out[0]), 6);
    check("tie_dec", int'(dec_bit[0]), 0);

    cycle(0, 0, 1, 100, 0, 120, 3, 1);
    check("norm_pm", int'(pm_out[0]), 36);
    check("norm_dec", int'(dec_bit[0]), 0);
    cycle(0, 0, 1, 20, 0, 30, 0, 1);
    check("norm_floor_pm", int'(pm_out[0]), 0);

    // Idle cycle with norm asserted must not change anything
    cycle(0, 0, 0, 200, 3, 200, 3, 1);
    check("norm_idle_pm", int'(pm_out[0]), 0);
    check("idle_vld", int'(out_valid[0]), 0);

    cycle(0, 0, 1, 254, 3, 255, 2, 0);
    check("sat_pm", int'(pm_out[0]), 255);
    check("sat_dec", int'(dec_bit[0]), 0);
    check("sat_flag", int'(sat[0]), 1);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 1, $urandom_range(0, 100), $urandom_range(0, 3),
            $urandom_range(0, 100), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      check("sat_sticky", int'(sat[0]), 1);
    end
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    check("sat_clr_sof", int'(sat[0]), 0);

    // sof beats in_valid
    cycle(0, 1, 1, 1, 1, 1, 1, 0);
    check("sof_pm_s3", int'(pm_out[2]), 64);
    check("sof_vld_s3", int'(out_valid[2]), 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 7, 1, 7, 1, 0);
      check("hold_pm_s3", int'(pm_out[2]), 64);
      check("hold_vld_s3", int'(out_valid[2]), 0);
    end

    // Reset mid-frame discards the step
    cycle(0, 0, 1, 30, 1, 40, 1, 0);
    cycle(1, 0, 1, 90, 1, 90, 1, 0);
    check("midrst_pm_s0", int'(pm_out[0]), 0);
    check("midrst_pm_s5", int'(pm_out[1]), 64);
    check("midrst_vld", int'(out_valid[0]), 0);

    // Randomised traffic, biased toward occasional saturation
    for (int k = 0; k < 400; k++) begin
      int pa, pb;
      pa = ($urandom_range(0, 3) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 255);
      pb = ($urandom_range(0, 3) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 255);
      cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 3) != 0), pa, $urandom_range(0, 3),
            pb, $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
